// File: rtl/fifo_pkt_wr_arbiter.sv
// Round-robin whole-packet arbiter sharing one FIFO write port among N_REQ sources.
// Optional per-requester completed-packet counters: define FIFO_PKT_ARB_STATS_EN.
module fifo_pkt_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 64,
  parameter int LEN_W     = 5,
  parameter int DEPTH_LOG = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*LEN_W-1:0]    i_req_len,
  input  logic [N_REQ*DATA_W-1:0]   i_data,
  input  logic [N_REQ-1:0]          i_valid,
  output logic [N_REQ-1:0]          o_ack,
  output logic [N_REQ-1:0]          o_grant,
  output logic                      o_busy,
  output logic [DATA_W-1:0]         o_fifo_wr_data,
  output logic                      o_fifo_wr_en,
`ifdef FIFO_PKT_ARB_STATS_EN
  output logic [N_REQ*16-1:0]       o_pkt_cnt,
`endif
  input  logic                      i_fifo_full,
  input  logic [DEPTH_LOG:0]        i_fifo_words
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [DEPTH_LOG:0] FIFO_DEPTH = {1'b1, {DEPTH_LOG{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_r;
  logic [N_REQ-1:0]   grant_r;
  logic [IDX_W-1:0]   gidx_r;
  logic [IDX_W-1:0]   last_r;
  logic [LEN_W-1:0]   cnt_r;

  logic [IDX_W-1:0]   cand_idx_s;
  logic               cand_found_s;
  logic [LEN_W-1:0]   cand_len_s;
  logic [DEPTH_LOG:0] free_s;
  logic [DEPTH_LOG:0] need_s;
  logic               fits_s;
  logic               wr_en_s;

  // Round-robin candidate search starting just after the last owner, with wrap.
  always_comb begin
    logic [IDX_W:0]   sum_v;
    logic [IDX_W-1:0] idx_v;
    logic             hit_v;
    sum_v        = '0;
    idx_v        = '0;
    hit_v        = 1'b0;
    cand_found_s = 1'b0;
    cand_idx_s   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum_v        = {1'b0, last_r} + (IDX_W+1)'(k);
      idx_v        = (sum_v >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum_v - (IDX_W+1)'(N_REQ)) : IDX_W'(sum_v);
      hit_v        = ~cand_found_s & i_req[idx_v];
      cand_idx_s   = hit_v ? idx_v : cand_idx_s;
      cand_found_s = cand_found_s | hit_v;
    end
  end

  // Room check: the whole candidate packet must fit in the FIFO before it is granted.
  always_comb begin
    cand_len_s = i_req_len[cand_idx_s*LEN_W +: LEN_W];
    free_s     = FIFO_DEPTH - i_fifo_words;
    need_s     = {{(DEPTH_LOG-LEN_W+1){1'b0}}, cand_len_s} + {{DEPTH_LOG{1'b0}}, 1'b1};
    fits_s     = (need_s <= free_s);
  end

  // Write path follows the registered grant with no added latency; full suppresses a write.
  always_comb begin
    wr_en_s        = (state_r == XFER) & i_valid[gidx_r] & ~i_fifo_full;
    o_fifo_wr_en   = wr_en_s;
    o_ack          = wr_en_s ? grant_r : {N_REQ{1'b0}};
    o_fifo_wr_data = (state_r == XFER) ? i_data[gidx_r*DATA_W +: DATA_W] : {DATA_W{1'b0}};
    o_grant        = grant_r;
    o_busy         = (state_r != IDLE);
  end

  // Arbitration FSM: grant in IDLE, count words in XFER, one settling cycle in GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      grant_r <= {N_REQ{1'b0}};
      gidx_r  <= {IDX_W{1'b0}};
      last_r  <= IDX_W'(N_REQ - 1);
      cnt_r   <= {LEN_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (cand_found_s && fits_s) begin
            grant_r <= {{(N_REQ-1){1'b0}}, 1'b1} << cand_idx_s;
            gidx_r  <= cand_idx_s;
            last_r  <= cand_idx_s;
            cnt_r   <= cand_len_s;
            state_r <= XFER;
          end else begin
            state_r <= IDLE;
          end
        end
        XFER: begin
          if (wr_en_s) begin
            if (cnt_r == {LEN_W{1'b0}}) begin
              state_r <= GAP;
              grant_r <= {N_REQ{1'b0}};
            end else begin
              cnt_r <= cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_r <= XFER;
          end
        end
        GAP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          grant_r <= {N_REQ{1'b0}};
        end
      endcase
    end
  end

`ifdef FIFO_PKT_ARB_STATS_EN
  logic [N_REQ*16-1:0] pkt_cnt_r;

  // Completed-packet counters bump on the write of each packet's last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_r <= {(N_REQ*16){1'b0}};
    end else if (wr_en_s && (cnt_r == {LEN_W{1'b0}})) begin
      pkt_cnt_r[gidx_r*16 +: 16] <= pkt_cnt_r[gidx_r*16 +: 16] + 16'd1;
    end else begin
      pkt_cnt_r <= pkt_cnt_r;
    end
  end

  assign o_pkt_cnt = pkt_cnt_r;
`endif

endmodule
